// File: rtl/lb_reset_pkg.sv
// Shared types and helpers for the lb_reset_seq reset sequencer.
// The FSM state enum, the rst_count width and a width helper for the hold/stagger counter.
package lb_reset_pkg;

    typedef enum logic [1:0] {
        S_ASSERT,
        S_HOLD,
        S_STAGGER,
        S_RUN
    } lb_state_e;

    localparam int RST_CNT_W = 8;

    // Bits needed to count down from max(a, b); never returns less than 1.
    function automatic int clog2_max(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return ($clog2(m) < 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/lb_reset_sync.sv
// Reset release synchroniser: STAGES-deep flop chain with D tied low and an async preset.
// The chain only advances while en is high, so a frozen sequencer also freezes the release.
module lb_reset_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic sync_rst
);

    logic [STAGES-1:0] r_chain;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_chain <= '1;
        end else if (en) begin
            r_chain <= {r_chain[STAGES-2:0], 1'b0};
        end
    end

    assign sync_rst = r_chain[STAGES-1];

endmodule

// File: rtl/lb_reset_seq.sv
// Reset sequencer: async assert, synchronised and staggered release of NUM_OUT resets.
// Build option LB_RESET_COUNT_EN adds a saturating counter of accepted soft resets.
//
// state     | meaning
// S_ASSERT  | all outputs asserted, waiting for the synchronised release
// S_HOLD    | all outputs asserted, counting down the hold time
// S_STAGGER | releasing outputs one by one, STAGGER cycles apart
// S_RUN     | all outputs released; a soft request restarts from S_HOLD
module lb_reset_seq
    import lb_reset_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 16,
    parameter int STAGGER     = 4,
    parameter int NUM_OUT     = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cs,
    input  logic                 soft_req,
    output logic [NUM_OUT-1:0]   rst_out,
    output logic                 done,
    output logic [RST_CNT_W-1:0] rst_count
);

    localparam int CNT_W = clog2_max(HOLD_CYCLES, STAGGER);
    localparam int IDX_W = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

    // The cycle spent leaving S_ASSERT already counts as the first hold cycle,
    // which keeps release at SYNC_STAGES + HOLD_CYCLES edges without shortening the synchroniser.
    localparam logic [CNT_W-1:0] HOLD_LD_SYNC = CNT_W'((HOLD_CYCLES > 1) ? HOLD_CYCLES - 2 : 0);
    localparam logic [CNT_W-1:0] HOLD_LD_SOFT = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STG_LD       = CNT_W'(STAGGER - 1);

    lb_state_e          r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [IDX_W-1:0]   r_idx, w_idx_nxt;
    logic [NUM_OUT-1:0] r_rst_out, w_rst_out_nxt;
    logic               w_sync_rst;
    logic               w_soft_acc;

    lb_reset_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .reset    (reset),
        .en       (cs),
        .sync_rst (w_sync_rst)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_ASSERT;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_rst_out <= '1;
        end else if (cs) begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_idx     <= w_idx_nxt;
            r_rst_out <= w_rst_out_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_idx_nxt     = r_idx;
        w_rst_out_nxt = r_rst_out;
        w_soft_acc    = 1'b0;
        case (r_state)
            S_ASSERT: begin
                w_rst_out_nxt = '1;
                if (!w_sync_rst) begin
                    if (HOLD_CYCLES == 1) begin
                        w_rst_out_nxt[0] = 1'b0;
                        w_cnt_nxt        = STG_LD;
                        w_idx_nxt        = IDX_W'(1);
                        w_state_nxt      = (NUM_OUT == 1) ? S_RUN : S_STAGGER;
                    end else begin
                        w_cnt_nxt   = HOLD_LD_SYNC;
                        w_state_nxt = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (r_cnt == '0) begin
                    w_rst_out_nxt[0] = 1'b0;
                    w_cnt_nxt        = STG_LD;
                    w_idx_nxt        = IDX_W'(1);
                    w_state_nxt      = (NUM_OUT == 1) ? S_RUN : S_STAGGER;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            S_STAGGER: begin
                if (r_cnt == '0) begin
                    w_rst_out_nxt[r_idx] = 1'b0;
                    w_cnt_nxt            = STG_LD;
                    if (r_idx == IDX_W'(NUM_OUT - 1)) begin
                        w_state_nxt = S_RUN;
                    end else begin
                        w_idx_nxt = r_idx + IDX_W'(1);
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            S_RUN: begin
                w_rst_out_nxt = '0;
                if (soft_req) begin
                    w_soft_acc    = 1'b1;
                    w_rst_out_nxt = '1;
                    w_cnt_nxt     = HOLD_LD_SOFT;
                    w_idx_nxt     = '0;
                    w_state_nxt   = S_HOLD;
                end
            end
            default: begin
                w_state_nxt   = S_ASSERT;
                w_rst_out_nxt = '1;
            end
        endcase
    end

    assign rst_out = r_rst_out;
    assign done    = (r_state == S_RUN);

`ifdef LB_RESET_COUNT_EN
    logic [RST_CNT_W-1:0] r_rst_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rst_count <= '0;
        end else if (cs && w_soft_acc && (r_rst_count != '1)) begin
            r_rst_count <= r_rst_count + RST_CNT_W'(1);
        end
    end

    assign rst_count = r_rst_count;
`else
    logic w_unused;
    assign w_unused  = w_soft_acc;
    assign rst_count = '0;
`endif

endmodule
